// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: state encoding, frame length and
// count width helpers. Frame length depends on the SIPO_PARITY_EN build macro.
package sipo_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_LAST    = 1'b1
  } sipo_state_t;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  function automatic int count_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for completed words, with a sticky
// overrun flag raised when a word arrives while the entry is still occupied.
module sipo_out_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          overrun
);

  logic free;

  assign free = !valid || ready;

  // A load and a consume on the same edge replace the word and keep valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      if (free) begin
        data  <= load_data;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer feeding a one-entry valid/ready buffer.
// Build macro SIPO_PARITY_EN appends a trailing parity bit and the parity_err port.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int ODD_PARITY = 0,
  localparam int FRAME     = frame_len(WIDTH),
  localparam int CW        = count_width(FRAME)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int SW = FRAME - 1;

  if (WIDTH < 2 || WIDTH > 32 || (ODD_PARITY != 0 && ODD_PARITY != 1)) begin : g_bad_param
    $error("sipo_deserializer: WIDTH must be 2..32 and ODD_PARITY 0 or 1");
  end

  sipo_state_t      state, state_next;
  logic [CW-1:0]    count_next;
  logic [SW-1:0]    shift_reg, shift_next;
  logic [FRAME-1:0] frame_bits;
  logic [WIDTH-1:0] word;
  logic             word_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_COLLECT;
      bit_count <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      bit_count <= count_next;
      shift_reg <= shift_next;
    end
  end

  // Bits are stored at their arrival index; the final bit is taken straight from in_bit.
  always_comb begin
    state_next = state;
    count_next = bit_count;
    shift_next = shift_reg;
    word_done  = 1'b0;
    if (flush) begin
      count_next = '0;
      shift_next = '0;
    end else if (in_valid) begin
      unique case (state)
        ST_COLLECT: begin
          for (int i = 0; i < SW; i++) begin
            if (bit_count == CW'(i)) shift_next[i] = in_bit;
          end
          count_next = bit_count + 1'b1;
        end
        ST_LAST: begin
          word_done  = 1'b1;
          count_next = '0;
        end
      endcase
    end
    state_next = (count_next == CW'(SW)) ? ST_LAST : ST_COLLECT;
  end

  assign frame_bits = {in_bit, shift_reg};

  always_comb begin
    word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word[i] = LSB_FIRST ? frame_bits[i] : frame_bits[WIDTH-1-i];
    end
  end

`ifdef SIPO_PARITY_EN
  logic         perr;
  logic [WIDTH:0] buf_q;

  // The parity flag travels with its word so it stays aligned with out_data.
  assign perr = ((^word) ^ frame_bits[FRAME-1]) != ODD_PARITY[0];

  sipo_out_buf #(.DW(WIDTH + 1)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (word_done),
    .load_data ({perr, word}),
    .ready     (out_ready),
    .data      (buf_q),
    .valid     (out_valid),
    .overrun   (overrun)
  );

  assign out_data   = buf_q[WIDTH-1:0];
  assign parity_err = out_valid && buf_q[WIDTH];
`else
  sipo_out_buf #(.DW(WIDTH)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (word_done),
    .load_data (word),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .overrun   (overrun)
  );
`endif

endmodule
